// File: rtl/vga_vram_wbuf_pkg.sv
// Shared types and widths for the VGA VRAM write buffer.
// The optional coalescing build is selected with VGA_VRAM_WBUF_COALESCE_EN.
package vga_vram_wbuf_pkg;

  localparam int VRAM_ADDR_W = 19;
  localparam int VRAM_DATA_W = 16;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_wr_entry_t;

endpackage

// File: rtl/vga_vram_wbuf_ram.sv
// Entry storage for the VRAM write buffer: one write port, asynchronous head read,
// plus a newest-entry read when VGA_VRAM_WBUF_COALESCE_EN is defined.
module vga_vram_wbuf_ram
  import vga_vram_wbuf_pkg::*;
#(
  parameter int P_DEPTH   = 16,
  parameter int P_DEPTH_N = 4
) (
  input  logic                 iCLOCK,
  input  logic                 i_we,
  input  logic [P_DEPTH_N-1:0] i_wr_idx,
  input  vram_wr_entry_t       i_wr_entry,
  input  logic [P_DEPTH_N-1:0] i_rd_idx,
`ifdef VGA_VRAM_WBUF_COALESCE_EN
  input  logic [P_DEPTH_N-1:0] i_nw_idx,
  output vram_wr_entry_t       o_nw_entry,
`endif
  output vram_wr_entry_t       o_rd_entry
);

  // Contents need no reset: the top gates every output with its occupancy count.
  vram_wr_entry_t r_mem [P_DEPTH];

  always_ff @(posedge iCLOCK) begin
    if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_entry;
    end
  end

  assign o_rd_entry = r_mem[i_rd_idx];

`ifdef VGA_VRAM_WBUF_COALESCE_EN
  assign o_nw_entry = r_mem[i_nw_idx];
`endif

endmodule

// File: rtl/vga_vram_write_buffer.sv
// Write-request FIFO between the VGA command controller and the SDRAM/VRAM port.
// Define VGA_VRAM_WBUF_COALESCE_EN to merge back-to-back writes to the same address.
module vga_vram_write_buffer
  import vga_vram_wbuf_pkg::*;
#(
  parameter int P_DEPTH   = 16,
  parameter int P_DEPTH_N = 4
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic                   iRESET_SYNC,
  input  logic                   iWR_REQ,
  input  logic [VRAM_ADDR_W-1:0] iWR_ADDR,
  input  logic [VRAM_DATA_W-1:0] iWR_DATA,
  output logic                   oWR_WAIT,
  output logic                   oMEM_REQ,
  output logic [VRAM_ADDR_W-1:0] oMEM_ADDR,
  output logic [VRAM_DATA_W-1:0] oMEM_DATA,
  input  logic                   iMEM_WAIT,
  output logic [P_DEPTH_N:0]     oCOUNT
);

  // Handshake: upstream transfers when iWR_REQ && !oWR_WAIT; downstream consumes
  // the head when oMEM_REQ && !iMEM_WAIT, and the head holds until consumed.
  localparam logic [P_DEPTH_N:0] LP_FULL = (P_DEPTH_N+1)'(P_DEPTH);
  localparam logic [P_DEPTH_N:0] LP_ONE  = (P_DEPTH_N+1)'(1);

  logic [P_DEPTH_N-1:0] r_wr_ptr;
  logic [P_DEPTH_N-1:0] r_rd_ptr;
  logic [P_DEPTH_N:0]   r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_alloc;
  logic [P_DEPTH_N-1:0] w_wr_idx;
  vram_wr_entry_t       w_wr_entry;
  vram_wr_entry_t       w_head;

  assign w_full     = (r_count == LP_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = iWR_REQ && !w_full;
  assign w_pop      = !w_empty && !iMEM_WAIT;
  assign w_wr_entry = '{addr: iWR_ADDR, data: iWR_DATA};

`ifdef VGA_VRAM_WBUF_COALESCE_EN
  logic [P_DEPTH_N-1:0] w_nw_idx;
  vram_wr_entry_t       w_nw_entry;
  logic                 w_coalesce;

  // Merging into an entry leaving this cycle would lose the write, so that case allocates.
  assign w_nw_idx   = r_wr_ptr - P_DEPTH_N'(1);
  assign w_coalesce = w_push && !w_empty && (iWR_ADDR == w_nw_entry.addr) &&
                      ((r_count != LP_ONE) || !w_pop);
  assign w_wr_idx   = w_coalesce ? w_nw_idx : r_wr_ptr;
  assign w_alloc    = w_push && !w_coalesce;
`else
  assign w_wr_idx   = r_wr_ptr;
  assign w_alloc    = w_push;
`endif

  vga_vram_wbuf_ram #(
    .P_DEPTH   (P_DEPTH),
    .P_DEPTH_N (P_DEPTH_N)
  ) u_ram (
    .iCLOCK     (iCLOCK),
    .i_we       (w_push && !iRESET_SYNC),
    .i_wr_idx   (w_wr_idx),
    .i_wr_entry (w_wr_entry),
    .i_rd_idx   (r_rd_ptr),
`ifdef VGA_VRAM_WBUF_COALESCE_EN
    .i_nw_idx   (w_nw_idx),
    .o_nw_entry (w_nw_entry),
`endif
    .o_rd_entry (w_head)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (iRESET_SYNC) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_alloc) begin
        r_wr_ptr <= r_wr_ptr + P_DEPTH_N'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + P_DEPTH_N'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // All outputs decode registered state only; iMEM_WAIT has no path to them.
  assign oWR_WAIT  = w_full;
  assign oMEM_REQ  = !w_empty;
  assign oMEM_ADDR = w_empty ? '0 : w_head.addr;
  assign oMEM_DATA = w_empty ? '0 : w_head.data;
  assign oCOUNT    = r_count;

endmodule

// File: tb/tb_vga_vram_write_buffer.sv
// Directed bench for vga_vram_write_buffer; expectations for the coalescing case
// follow VGA_VRAM_WBUF_COALESCE_EN as the DUT is built.
module tb_vga_vram_write_buffer;

  logic        iCLOCK;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic        iWR_REQ;
  logic [18:0] iWR_ADDR;
  logic [15:0] iWR_DATA;
  logic        oWR_WAIT;
  logic        oMEM_REQ;
  logic [18:0] oMEM_ADDR;
  logic [15:0] oMEM_DATA;
  logic        iMEM_WAIT;
  logic [4:0]  oCOUNT;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];
  logic [34:0] exp_e;

  vga_vram_write_buffer dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iWR_REQ     (iWR_REQ),
    .iWR_ADDR    (iWR_ADDR),
    .iWR_DATA    (iWR_DATA),
    .oWR_WAIT    (oWR_WAIT),
    .oMEM_REQ    (oMEM_REQ),
    .oMEM_ADDR   (oMEM_ADDR),
    .oMEM_DATA   (oMEM_DATA),
    .iMEM_WAIT   (iMEM_WAIT),
    .oCOUNT      (oCOUNT)
  );

  // Clock and reset
  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [34:0] e);
    check({tag, "_req"}, 32'(oMEM_REQ), 32'd1);
    check({tag, "_addr"}, 32'(oMEM_ADDR), 32'(e[34:16]));
    check({tag, "_data"}, 32'(oMEM_DATA), 32'(e[15:0]));
  endtask

  // Driver: one accepted-or-not write request on the next edge
  task automatic drive_write(input logic [18:0] a, input logic [15:0] d);
    iWR_REQ  = 1'b1;
    iWR_ADDR = a;
    iWR_DATA = d;
    tick();
    iWR_REQ  = 1'b0;
  endtask

  initial begin
    inRESET     = 1'b0;
    iRESET_SYNC = 1'b0;
    iWR_REQ     = 1'b0;
    iWR_ADDR    = '0;
    iWR_DATA    = '0;
    iMEM_WAIT   = 1'b0;

    // Asynchronous reset held low
    repeat (3) tick();
    check("rst_wait",  32'(oWR_WAIT),  32'd0);
    check("rst_req",   32'(oMEM_REQ),  32'd0);
    check("rst_addr",  32'(oMEM_ADDR), 32'd0);
    check("rst_data",  32'(oMEM_DATA), 32'd0);
    check("rst_count", 32'(oCOUNT),    32'd0);
    inRESET = 1'b1;
    repeat (3) tick();
    check("idle_req",   32'(oMEM_REQ), 32'd0);
    check("idle_count", 32'(oCOUNT),   32'd0);

    // Single write appears one cycle later and is consumed
    drive_write(19'h00123, 16'h0F0F);
    check("single_count", 32'(oCOUNT), 32'd1);
    check_head("single", {19'h00123, 16'h0F0F});
    tick();
    check("single_pop_count", 32'(oCOUNT),    32'd0);
    check("single_pop_req",   32'(oMEM_REQ),  32'd0);
    check("single_pop_addr",  32'(oMEM_ADDR), 32'd0);

    // Fill while stalled: 17 requests, 17th must be dropped
    iMEM_WAIT = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_write(19'(i), 16'hA000 + 16'(i));
      if (i == 14) check("fill15_wait", 32'(oWR_WAIT), 32'd0);
      if (i == 15) check("fill16_wait", 32'(oWR_WAIT), 32'd1);
    end
    check("fill_count", 32'(oCOUNT),   32'd16);
    check("fill_wait",  32'(oWR_WAIT), 32'd1);
    check_head("stall_head", {19'd0, 16'hA000});
    tick();
    check_head("stall_hold", {19'd0, 16'hA000});
    iMEM_WAIT = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j == 0) check("drain0_wait", 32'(oWR_WAIT), 32'd1);
      if (j == 1) check("drain1_wait", 32'(oWR_WAIT), 32'd0);
      check_head("drain", {19'(j), 16'hA000 + 16'(j)});
      tick();
    end
    check("drain_count", 32'(oCOUNT),   32'd0);
    check("drain_req",   32'(oMEM_REQ), 32'd0);

    // Steady push+pop at occupancy 5
    iMEM_WAIT = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_write(19'h00200 + 19'(k), 16'(k));
      exp_q.push_back({19'h00200 + 19'(k), 16'(k)});
    end
    check("pp_fill_count", 32'(oCOUNT), 32'd5);
    iMEM_WAIT = 1'b0;
    iWR_REQ   = 1'b1;
    for (int c = 0; c < 40; c++) begin
      iWR_ADDR = 19'h00300 + 19'(c);
      iWR_DATA = 16'h5000 + 16'(c);
      check_head("pp_head", exp_q[0]);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back({iWR_ADDR, iWR_DATA});
      check("pp_count", 32'(oCOUNT), 32'd5);
    end
    iWR_REQ = 1'b0;
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      check_head("pp_drain", exp_e);
      tick();
    end
    check("pp_end_count", 32'(oCOUNT), 32'd0);

    // Synchronous flush at count 9, with a write pending in the same cycle
    iMEM_WAIT = 1'b1;
    for (int k = 0; k < 9; k++) drive_write(19'h00400 + 19'(k), 16'(k));
    check("flush_pre_count", 32'(oCOUNT), 32'd9);
    iRESET_SYNC = 1'b1;
    iWR_REQ     = 1'b1;
    iWR_ADDR    = 19'h00777;
    iWR_DATA    = 16'h7777;
    tick();
    iRESET_SYNC = 1'b0;
    iWR_REQ     = 1'b0;
    check("flush_count", 32'(oCOUNT),    32'd0);
    check("flush_req",   32'(oMEM_REQ),  32'd0);
    check("flush_wait",  32'(oWR_WAIT),  32'd0);
    check("flush_addr",  32'(oMEM_ADDR), 32'd0);
    drive_write(19'h00555, 16'h1234);
    check("post_flush_count", 32'(oCOUNT), 32'd1);
    check_head("post_flush", {19'h00555, 16'h1234});
    iMEM_WAIT = 1'b0;
    tick();
    check("post_flush_empty", 32'(oCOUNT), 32'd0);

    // Full with simultaneous pop: push blocked, WAIT falls after
    iMEM_WAIT = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive_write(19'h01000 + 19'(k), 16'hC000 + 16'(k));
      exp_q.push_back({19'h01000 + 19'(k), 16'hC000 + 16'(k)});
    end
    check("full_pp_pre_wait", 32'(oWR_WAIT), 32'd1);
    iMEM_WAIT = 1'b0;
    drive_write(19'h01FFF, 16'hDEAD);
    void'(exp_q.pop_front());
    check("full_pp_count", 32'(oCOUNT),   32'd15);
    check("full_pp_wait",  32'(oWR_WAIT), 32'd0);
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      check_head("full_pp_drain", exp_e);
      tick();
    end
    check("full_pp_end_req", 32'(oMEM_REQ), 32'd0);

    // Same-address back-to-back writes while stalled
    iMEM_WAIT = 1'b1;
    drive_write(19'h00100, 16'h0001);
    drive_write(19'h00100, 16'h0002);
`ifdef VGA_VRAM_WBUF_COALESCE_EN
    check("coal_count", 32'(oCOUNT), 32'd1);
    check_head("coal_head", {19'h00100, 16'h0002});
    iMEM_WAIT = 1'b0;
    tick();
`else
    check("coal_count", 32'(oCOUNT), 32'd2);
    check_head("coal_first", {19'h00100, 16'h0001});
    iMEM_WAIT = 1'b0;
    tick();
    check_head("coal_second", {19'h00100, 16'h0002});
    tick();
`endif
    check("coal_end_count", 32'(oCOUNT),   32'd0);
    check("coal_end_req",   32'(oMEM_REQ), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
